round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter_pkg.sv | 17 +
 rtl/rr_grant.sv | 35 +++
 rtl/round_robin_arbiter.sv | 133 +++++++++++++
 tb/tb_round_robin_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, queue count and
// the position of the destination field inside each word.
package round_robin_arbiter_pkg;

  localparam int unsigned NumQueues = 4;

  // The destination field sits at the top of the word: data[MSB-offset -: width]
  localparam int unsigned DestWidth     = 2;
  localparam int unsigned DestMsbOffset = 0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StPause  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant search: first asserted request at or above the
// pointer, wrapping modulo the request count.
module rr_grant #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [NumReq-1:0] o_grant,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_valid
);

  int unsigned     w_cand;
  logic [IdxW-1:0] w_idx;

  // Scan candidates in priority order starting at the pointer; first hit wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    w_idx   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      w_cand = (32'(i_ptr) + off) % NumReq;
      w_idx  = IdxW'(w_cand);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: pops one upstream queue per cycle, and two cycles later
// pushes the returned word to the downstream queue named by its destination field.
module round_robin_arbiter
  import round_robin_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 12,
  parameter int unsigned NUM_QUEUES = NumQueues
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [NUM_QUEUES-1:0]           fifo_empty,
  input  logic [NUM_QUEUES-1:0]           fifo_valid,
  input  logic [NUM_QUEUES*DATA_SIZE-1:0] fifo_data,
  input  logic [NUM_QUEUES-1:0]           down_almost_full,
  output logic [NUM_QUEUES-1:0]           pop,
  output logic [NUM_QUEUES-1:0]           push,
  output logic [DATA_SIZE-1:0]            data_out,
  output logic                            idle,
  output logic                            paused,
  output logic                            arb_error
);

  localparam int unsigned PtrW = $clog2(NUM_QUEUES);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [PtrW-1:0]         r_ptr;
  logic [NUM_QUEUES-1:0]   r_pop_prev;
  logic [NUM_QUEUES-1:0]   r_push;
  logic [DATA_SIZE-1:0]    r_data;
  logic                    r_err;

  logic [NUM_QUEUES-1:0]   w_req;
  logic [NUM_QUEUES-1:0]   w_grant;
  logic [NUM_QUEUES-1:0]   w_pop;
  logic [PtrW-1:0]         w_grant_idx;
  logic                    w_grant_valid;
  logic                    w_any_full;
  logic                    w_any_req;
  logic                    w_vld_err;
  logic [DATA_SIZE-1:0]    w_word;
  logic [DestWidth-1:0]    w_dest;

  assign w_req      = ~fifo_empty;
  assign w_any_full = |down_almost_full;
  assign w_any_req  = |w_req;

  rr_grant #(
    .NumReq (NUM_QUEUES),
    .IdxW   (PtrW)
  ) u_rr_grant (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_valid)
  );

  // Mealy pop: only in ACTIVE with no back-pressure, and never while in reset
  always_comb begin
    w_pop = '0;
    if (reset_L && (r_state == StActive) && !w_any_full && w_grant_valid) begin
      w_pop = w_grant;
    end
  end

  // Next state: back-pressure dominates, otherwise follow queue occupancy
  always_comb begin
    w_state_next = r_state;
    if (w_any_full) begin
      w_state_next = StPause;
    end else begin
      case (r_state)
        StIdle:   if (w_any_req) w_state_next = StActive;
        StActive: if (!w_any_req) w_state_next = StIdle;
        StPause:  w_state_next = w_any_req ? StActive : StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  // Merge the returning word; valid is expected one-hot so OR-merge is a mux
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (fifo_valid[i]) w_word = w_word | fifo_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Valid without a matching pop last cycle, or multi-hot valid, is a protocol error
  assign w_vld_err = (|(fifo_valid & ~r_pop_prev)) || ($countones(fifo_valid) > 1);
  assign w_dest    = w_word[DATA_SIZE-1-DestMsbOffset -: DestWidth];

  // FSM state, round-robin pointer and pop history
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_pop_prev <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pop_prev <= w_pop;
      if (|w_pop) begin
        r_ptr <= (w_grant_idx == PtrW'(NUM_QUEUES - 1)) ? '0 : w_grant_idx + PtrW'(1);
      end
    end
  end

  // Output stage: register the push strobe and word; data holds between pushes
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_push <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else if (w_vld_err) begin
      r_push <= '0;
      r_err  <= 1'b1;
    end else if (|fifo_valid) begin
      r_push <= NUM_QUEUES'(1) << w_dest;
      r_data <= w_word;
    end else begin
      r_push <= '0;
    end
  end

  assign pop       = w_pop;
  assign push      = r_push;
  assign data_out  = r_data;
  assign arb_error = r_err;
  assign idle      = (r_state == StIdle);
  assign paused    = (r_state == StPause);

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench: upstream FIFOs are bench queues, and a behavioural model
// predicts pops, pushes and status flags cycle by cycle.
module tb_round_robin_arbiter;

  localparam int DW = 12;
  localparam int NQ = 4;

  logic               clk;
  logic               reset_L;
  logic [NQ-1:0]      fifo_empty;
  logic [NQ-1:0]      fifo_valid;
  logic [NQ*DW-1:0]   fifo_data;
  logic [NQ-1:0]      down_almost_full;
  logic [NQ-1:0]      pop;
  logic [NQ-1:0]      push;
  logic [DW-1:0]      data_out;
  logic               idle;
  logic               paused;
  logic               arb_error;

  round_robin_arbiter #(
    .DATA_SIZE  (DW),
    .NUM_QUEUES (NQ)
  ) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .fifo_empty       (fifo_empty),
    .fifo_valid       (fifo_valid),
    .fifo_data        (fifo_data),
    .down_almost_full (down_almost_full),
    .pop              (pop),
    .push             (push),
    .data_out         (data_out),
    .idle             (idle),
    .paused           (paused),
    .arb_error        (arb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Upstream FIFO contents
  logic [DW-1:0] fq [NQ][$];

  // Model: 0 idle, 1 active, 2 pause
  int              m_state;
  int              m_ptr;
  logic [NQ-1:0]   m_prev_pop;
  logic [NQ-1:0]   m_push;
  logic [DW-1:0]   m_dout;
  logic            m_err;
  logic [NQ-1:0]   vld_next;
  logic [NQ*DW-1:0] data_next;

  logic [NQ-1:0]   daf_v;
  logic            inject_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state    = 0;
    m_ptr      = 0;
    m_prev_pop = '0;
    m_push     = '0;
    m_dout     = '0;
    m_err      = 1'b0;
    vld_next   = '0;
    data_next  = 48'({$urandom(), $urandom()});
    for (int i = 0; i < NQ; i++) fq[i].delete();
  endtask

  // Entered at posedge+1: drive inputs, predict, check at negedge, advance model
  task automatic cycle();
    logic [NQ-1:0] emp;
    logic [NQ-1:0] epop;
    logic [NQ-1:0] v;
    logic [DW-1:0] w;
    int            g;
    for (int i = 0; i < NQ; i++) emp[i] = (fq[i].size() == 0);
    fifo_empty       = emp;
    down_almost_full = daf_v;
    v                = vld_next;
    fifo_data        = data_next;
    if (inject_v) begin
      v[3]               = 1'b1;
      fifo_data[3*DW +: DW] = 12'h5A5;
    end
    fifo_valid = v;

    // Grant: first non-empty queue from the pointer upward, modulo NQ
    epop = '0;
    if (m_state == 1 && daf_v == '0) begin
      for (int k = 0; k < NQ; k++) begin
        g = (m_ptr + k) % NQ;
        if (epop == '0 && !emp[g]) epop[g] = 1'b1;
      end
    end

    @(negedge clk);
    chk("pop",       32'(pop),       32'(epop));
    chk("push",      32'(push),      32'(m_push));
    chk("data_out",  32'(data_out),  32'(m_dout));
    chk("idle",      32'(idle),      32'(m_state == 0));
    chk("paused",    32'(paused),    32'(m_state == 2));
    chk("arb_error", 32'(arb_error), 32'(m_err));

    // Word returning this cycle is pushed next cycle unless it breaks protocol
    if ((v & ~m_prev_pop) != '0 || $countones(v) > 1) begin
      m_err  = 1'b1;
      m_push = '0;
    end else if (v != '0) begin
      w = '0;
      for (int k = 0; k < NQ; k++) if (v[k]) w = fifo_data[k*DW +: DW];
      m_push = 4'b0001 << w[DW-1 -: 2];
      m_dout = w;
    end else begin
      m_push = '0;
    end
    m_prev_pop = epop;

    vld_next  = '0;
    data_next = 48'({$urandom(), $urandom()});
    for (int k = 0; k < NQ; k++) begin
      if (epop[k]) begin
        data_next[k*DW +: DW] = fq[k].pop_front();
        vld_next[k]           = 1'b1;
        m_ptr                 = (k + 1) % NQ;
      end
    end

    if (daf_v != '0)      m_state = 2;
    else if (emp != '1)   m_state = 1;
    else                  m_state = 0;

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Entered at posedge+1: assert reset mid-cycle, check async clear, release
  task automatic do_reset();
    reset_L    = 1'b0;
    fifo_valid = '0;
    fifo_empty = '0;
    #1;
    chk("rst_push",   32'(push),      32'(0));
    chk("rst_dout",   32'(data_out),  32'(0));
    chk("rst_pop",    32'(pop),       32'(0));
    chk("rst_idle",   32'(idle),      32'(1));
    chk("rst_paused", 32'(paused),    32'(0));
    chk("rst_err",    32'(arb_error), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L          = 1'b0;
    fifo_empty       = '1;
    fifo_valid       = '0;
    fifo_data        = '0;
    down_almost_full = '0;
    daf_v            = '0;
    inject_v         = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // All queues loaded, pointer at 0: pops 0,1,2,3,0,...
    for (int q = 0; q < NQ; q++)
      for (int j = 0; j < 3; j++) fq[q].push_back(12'($urandom()));
    run(20);

    // Single word C05 in queue 2 lands in downstream queue 3
    fq[2].push_back(12'hC05);
    run(6);

    // Back-pressure right after pop[0]: in-flight word still delivered
    do_reset();
    fq[0].push_back(12'h123);
    fq[0].push_back(12'h9AB);
    fq[1].push_back(12'h456);
    fq[1].push_back(12'hE01);
    cycle();
    cycle();
    daf_v = 4'b0010;
    run(3);
    daf_v = '0;
    run(10);

    // Unsolicited valid on queue 3: sticky error, word dropped
    inject_v = 1'b1;
    cycle();
    inject_v = 1'b0;
    run(3);
    do_reset();
    run(2);

    // Reset one cycle after pop[1]: nothing delivered after release
    fq[0].push_back(12'h8A3);
    run(6);
    fq[1].push_back(12'h4B7);
    cycle();
    cycle();
    do_reset();
    run(4);

    // Pointer at 1 with queues 0 and 3 loaded: grant 3 then wrap to 0
    fq[0].push_back(12'h111);
    run(6);
    fq[0].push_back(12'h222);
    fq[3].push_back(12'h3F3);
    run(8);

    // Random traffic with occasional back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) fq[$urandom_range(0, NQ - 1)].push_back(12'($urandom()));
      daf_v = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cycle();
    end
    daf_v = '0;
    run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
